// File: rtl/id_stage_hz.sv
// id_stage_hz: decode stage with register file and load-use hazard detection.
//
// Decodes one instruction per cycle from IR/PC into registered control and
// operand outputs, one cycle after IR is presented. It also holds the
// register file, which takes the writeback port.
//
// Ports
//   clk, rst                  clock, asynchronous active-low reset
//   in_valid, PC, IR          instruction from fetch (PC already incremented)
//   flush                     kill the instruction in decode
//   DX_MemRead, DX_RD         load in execute and its destination
//   MW_RegWrite, MW_RD,       writeback port
//   MW_wdata
//   hold                      combinational load-use stall to fetch
//   out_valid .. illegal      registered control flags
//   ALUctr                    registered ALU op
//   A, B, MD, NPC, JT         registered operands, store data, PC, jump target
//   RD, imm                   registered destination and raw immediate
module id_stage_hz #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int FWD_WB = 1,
    localparam int RAW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    input  logic [XLEN-1:0] PC,
    input  logic [31:0]     IR,
    input  logic            flush,
    input  logic            DX_MemRead,
    input  logic [RAW-1:0]  DX_RD,
    input  logic            MW_RegWrite,
    input  logic [RAW-1:0]  MW_RD,
    input  logic [XLEN-1:0] MW_wdata,
    output logic            hold,
    output logic            out_valid,
    output logic            MemtoReg,
    output logic            RegWrite,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            branch,
    output logic            bne,
    output logic            jump,
    output logic            illegal,
    output logic [2:0]      ALUctr,
    output logic [XLEN-1:0] A,
    output logic [XLEN-1:0] B,
    output logic [XLEN-1:0] MD,
    output logic [XLEN-1:0] NPC,
    output logic [XLEN-1:0] JT,
    output logic [RAW-1:0]  RD,
    output logic [15:0]     imm
);

    logic [XLEN-1:0] rf [NREG];

    logic [5:0]     opcode;
    logic [5:0]     funct;
    logic [RAW-1:0] rs_idx;
    logic [RAW-1:0] rt_idx;
    logic [RAW-1:0] rdr_idx;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] imm_sx;
    logic [XLEN-1:0] imm_zx;
    logic            uses_rt;

    assign opcode  = IR[31:26];
    assign funct   = IR[5:0];
    assign rs_idx  = RAW'(IR[25:21]);
    assign rt_idx  = RAW'(IR[20:16]);
    assign rdr_idx = RAW'(IR[15:11]);
    assign imm_sx  = {{(XLEN-16){IR[15]}}, IR[15:0]};
    assign imm_zx  = {{(XLEN-16){1'b0}}, IR[15:0]};

    // Register file; entry 0 is never written so it stays zero after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else if (MW_RegWrite && MW_RD != '0) begin
            rf[MW_RD] <= MW_wdata;
        end
    end

    // Read ports with optional write-through bypass from writeback.
    always_comb begin
        rs_val = rf[rs_idx];
        if (rs_idx == '0)
            rs_val = '0;
        else if (FWD_WB != 0 && MW_RegWrite && MW_RD == rs_idx)
            rs_val = MW_wdata;
    end

    always_comb begin
        rt_val = rf[rt_idx];
        if (rt_idx == '0)
            rt_val = '0;
        else if (FWD_WB != 0 && MW_RegWrite && MW_RD == rt_idx)
            rt_val = MW_wdata;
    end

    // Load-use stall: only rt-reading formats compare against rt.
    assign uses_rt = (opcode == 6'd0) || (opcode == 6'd4) ||
                     (opcode == 6'd5) || (opcode == 6'd43);

    assign hold = in_valid && !flush && DX_MemRead && DX_RD != '0 &&
                  (DX_RD == rs_idx || (uses_rt && DX_RD == rt_idx));

    logic            d_legal;
    logic [2:0]      d_alu;
    logic [XLEN-1:0] d_a;
    logic [XLEN-1:0] d_b;
    logic [RAW-1:0]  d_rd;
    logic            d_rw, d_mr, d_mw, d_mtr, d_br, d_bne, d_jmp;

    always_comb begin
        d_legal = 1'b1;
        d_alu   = 3'd0;
        d_a     = rs_val;
        d_b     = imm_sx;
        d_rd    = rt_idx;
        d_rw    = 1'b0;
        d_mr    = 1'b0;
        d_mw    = 1'b0;
        d_mtr   = 1'b0;
        d_br    = 1'b0;
        d_bne   = 1'b0;
        d_jmp   = 1'b0;
        case (opcode)
            6'd0: begin
                d_b  = rt_val;
                d_rd = rdr_idx;
                d_rw = 1'b1;
                case (funct)
                    6'd32:   d_alu = 3'd0;
                    6'd34:   d_alu = 3'd1;
                    6'd36:   d_alu = 3'd2;
                    6'd37:   d_alu = 3'd3;
                    6'd42:   d_alu = 3'd4;
                    default: d_legal = 1'b0;
                endcase
            end
            6'd35: begin
                d_mr  = 1'b1;
                d_mtr = 1'b1;
                d_rw  = 1'b1;
            end
            6'd43: d_mw = 1'b1;
            6'd4: begin
                d_b   = rt_val;
                d_alu = 3'd5;
                d_br  = 1'b1;
            end
            6'd5: begin
                d_b   = rt_val;
                d_alu = 3'd6;
                d_br  = 1'b1;
                d_bne = 1'b1;
            end
            6'd2:  d_jmp = 1'b1;
            6'd8:  d_rw = 1'b1;
            6'd10: begin
                d_alu = 3'd4;
                d_rw  = 1'b1;
            end
            6'd12: begin
                d_b   = imm_zx;
                d_alu = 3'd2;
                d_rw  = 1'b1;
            end
            6'd13: begin
                d_b   = imm_zx;
                d_alu = 3'd3;
                d_rw  = 1'b1;
            end
            6'd15: begin
                d_a  = '0;
                d_b  = {IR[15:0], {(XLEN-16){1'b0}}};
                d_rw = 1'b1;
            end
            default: d_legal = 1'b0;
        endcase
    end

    // Bubbles and illegal instructions only touch the flags; data outputs
    // (and MemtoReg/ALUctr) keep their previous values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            MemtoReg  <= 1'b0;
            RegWrite  <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            branch    <= 1'b0;
            bne       <= 1'b0;
            jump      <= 1'b0;
            illegal   <= 1'b0;
            ALUctr    <= '0;
            A         <= '0;
            B         <= '0;
            MD        <= '0;
            NPC       <= '0;
            JT        <= '0;
            RD        <= '0;
            imm       <= '0;
        end else if (flush || hold || !in_valid || !d_legal) begin
            out_valid <= 1'b0;
            RegWrite  <= 1'b0;
            MemRead   <= 1'b0;
            MemWrite  <= 1'b0;
            branch    <= 1'b0;
            bne       <= 1'b0;
            jump      <= 1'b0;
            illegal   <= !(flush || hold || !in_valid);
        end else begin
            out_valid <= 1'b1;
            MemtoReg  <= d_mtr;
            RegWrite  <= d_rw;
            MemRead   <= d_mr;
            MemWrite  <= d_mw;
            branch    <= d_br;
            bne       <= d_bne;
            jump      <= d_jmp;
            illegal   <= 1'b0;
            ALUctr    <= d_alu;
            A         <= d_a;
            B         <= d_b;
            MD        <= rt_val;
            NPC       <= PC;
            JT        <= {PC[XLEN-1:28], IR[25:0], 2'b00};
            RD        <= d_rd;
            imm       <= IR[15:0];
        end
    end

endmodule
